// File: rtl/bitty_uart_if.sv
// Host-side bundle for bitty_uart: transmit request/ready, receive FIFO head and error pulses.
interface bitty_uart_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_overrun;
  logic                 rx_frame_err;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_overrun, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_overrun, rx_frame_err
  );
endinterface

// File: rtl/bitty_uart.sv
// bitty_uart: full-duplex UART with an RX FIFO and overrun / framing-error pulses.
// Define BITTY_UART_PARITY_EN to insert an even-parity bit after the data on TX and RX.
module bitty_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  bitty_uart_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

  // ---------------------------------------------------------------- transmitter
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef BITTY_UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [BW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_ready_q, tx_ready_n;
  logic                 tx_line;
  logic                 tx_bit_end;
`ifdef BITTY_UART_PARITY_EN
  logic                 tx_par, tx_par_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_ready_q <= 1'b1;
      tx         <= 1'b1;
`ifdef BITTY_UART_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else begin
      tx_state   <= tx_state_n;
      tx_cnt     <= tx_cnt_n;
      tx_idx     <= tx_idx_n;
      tx_shift   <= tx_shift_n;
      tx_ready_q <= tx_ready_n;
      tx         <= tx_line;
`ifdef BITTY_UART_PARITY_EN
      tx_par     <= tx_par_n;
`endif
    end
  end

  // tx is registered from the state, so the line lags the FSM by one cycle;
  // ready is likewise only restored one cycle after the FSM re-enters idle.
  always_comb begin
    tx_state_n = tx_state;
    tx_bit_end = (tx_cnt == BIT_END);
    tx_cnt_n   = tx_bit_end ? '0 : tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_ready_n = tx_ready_q;
    tx_line    = 1'b1;
`ifdef BITTY_UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_n   = '0;
        tx_ready_n = 1'b1;
        if (bus.tx_valid && tx_ready_q) begin
          tx_state_n = TX_START;
          tx_shift_n = bus.tx_data;
          tx_ready_n = 1'b0;
`ifdef BITTY_UART_PARITY_EN
          tx_par_n   = ^bus.tx_data;
`endif
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) begin
          tx_state_n = TX_DATA;
          tx_idx_n   = '0;
        end
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end) begin
          tx_shift_n = tx_shift >> 1;
          tx_idx_n   = tx_idx + 1'b1;
          if (tx_idx == LAST_BIT) begin
`ifdef BITTY_UART_PARITY_EN
            tx_state_n = TX_PARITY;
`else
            tx_state_n = TX_STOP;
`endif
          end
        end
      end
`ifdef BITTY_UART_PARITY_EN
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_bit_end) tx_state_n = TX_STOP;
      end
`endif
      TX_STOP: begin
        tx_line = 1'b1;
        if (tx_bit_end) tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign bus.tx_ready = tx_ready_q;

  // ------------------------------------------------------------------- receiver
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef BITTY_UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  rx_state_t            rx_state, rx_state_n;
  logic                 rx_s1, rx_s2, rx_s3;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [BW-1:0]        rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_bit_end;
  logic                 push_req, err_req;
`ifdef BITTY_UART_PARITY_EN
  logic                 rx_par, rx_par_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
`ifdef BITTY_UART_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
`ifdef BITTY_UART_PARITY_EN
      rx_par   <= rx_par_n;
`endif
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_bit_end = (rx_cnt == BIT_END);
    rx_cnt_n   = rx_bit_end ? '0 : rx_cnt + 1'b1;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    push_req   = 1'b0;
    err_req    = 1'b0;
`ifdef BITTY_UART_PARITY_EN
    rx_par_n   = rx_par;
`endif
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_s3 && !rx_s2) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
          rx_idx_n   = rx_idx + 1'b1;
          if (rx_idx == LAST_BIT) begin
`ifdef BITTY_UART_PARITY_EN
            rx_state_n = RX_PARITY;
`else
            rx_state_n = RX_STOP;
`endif
          end
        end
      end
`ifdef BITTY_UART_PARITY_EN
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_par_n   = rx_s2;
          rx_state_n = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_state_n = RX_IDLE;
`ifdef BITTY_UART_PARITY_EN
          if (!rx_s2 || ((^rx_shift) ^ rx_par)) err_req = 1'b1;
`else
          if (!rx_s2) err_req = 1'b1;
`endif
          else push_req = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ RX FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, wptr_n, rptr, rptr_n;
  logic [NW-1:0]        count, count_n;
  logic [DATA_BITS-1:0] rx_data_q, head_n;
  logic                 rx_valid_q, overrun_q, frame_err_q;
  logic                 pop, push, full;

  // The head is registered, so the next head is forwarded from the incoming
  // byte when it lands in the slot the read pointer is about to point at.
  always_comb begin
    pop     = rx_valid_q && bus.rx_ready;
    full    = (count == FULL_CNT);
    push    = push_req && (!full || pop);
    wptr_n  = push ? wptr + 1'b1 : wptr;
    rptr_n  = pop ? rptr + 1'b1 : rptr;
    count_n = count + NW'(push) - NW'(pop);
    head_n  = (push && (rptr_n == wptr)) ? rx_shift : mem[rptr_n];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      count       <= count_n;
      rx_valid_q  <= (count_n != '0);
      if (count_n != '0) rx_data_q <= head_n;
      overrun_q   <= push_req && full && !pop;
      frame_err_q <= err_req;
    end
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_overrun   = overrun_q;
  assign bus.rx_frame_err = frame_err_q;
endmodule

// File: tb/tb_bitty_uart.sv
// Bench for bitty_uart: TX waveform, loopback, FIFO/overrun, framing errors, glitches, async reset.
module tb_bitty_uart;
  localparam int C     = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef BITTY_UART_PARITY_EN
  localparam int F   = DB + 3;
  localparam bit PAR = 1'b1;
`else
  localparam int F   = DB + 2;
  localparam bit PAR = 1'b0;
`endif
  localparam int LAT = F * C - C / 2 + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, rx;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] data;
    bit         stop_bit;
    bit         par_bad;
    bit         exp_err;
    bit         exp_ovr;
    int         pops;
  } vec_t;
  vec_t vt[11];

  bitty_uart_if #(.DATA_BITS(DB)) bus ();

  bitty_uart #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .bus(bus)
  );

  assign rx = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_overrun === 1'b1) ovr_cnt++;
    if (bus.rx_frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line levels of one frame, index 0 = start bit.
  function automatic logic [F-1:0] frame_bits(input logic [7:0] d, input bit stop_bit, input bit par_bad);
    logic [F-1:0] f;
    f = '0;
    for (int i = 0; i < DB; i++) f[i+1] = d[i];
    if (PAR) f[F-2] = (^d) ^ par_bad;
    f[F-1] = stop_bit;
    return f;
  endfunction

  task automatic rx_frame(input logic [7:0] d, input bit stop_bit, input bit par_bad,
                          input bit exp_err, input bit exp_ovr);
    logic [F-1:0] fr;
    int e0, o0;
    fr = frame_bits(d, stop_bit, par_bad);
    e0 = err_cnt;
    o0 = ovr_cnt;
    for (int i = 0; i < F; i++) begin
      rx_drv = fr[i];
      repeat (C) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (C) @(posedge clk);
    #1;
    check("rx_frame_err_pulses", 32'(err_cnt - e0), 32'(exp_err));
    check("rx_overrun_pulses", 32'(ovr_cnt - o0), 32'(exp_ovr));
    if (!exp_err && !exp_ovr) q.push_back(d);
    check("rx_valid", 32'(bus.rx_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("rx_head", 32'(bus.rx_data), 32'(q[0]));
  endtask

  task automatic pop_one();
    logic [7:0] e;
    if (q.size() == 0) return;
    e = q.pop_front();
    check("pop_valid", 32'(bus.rx_valid), 32'd1);
    check("pop_data", 32'(bus.rx_data), 32'(e));
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    check("after_pop_valid", 32'(bus.rx_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("after_pop_head", 32'(bus.rx_data), 32'(q[0]));
  endtask

  task automatic tx_send(input logic [7:0] d, input bit poke);
    logic [F-1:0] fr;
    int w;
    fr = frame_bits(d, 1'b1, 1'b0);
    w = 0;
    while (bus.tx_ready !== 1'b1 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("tx_ready_before", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~d;
    check("tx_ready_drop", 32'(bus.tx_ready), 32'd0);
    for (int k = 1; k <= F * C; k++) begin
      if (poke && k == 2 * C + 1) bus.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b0;
      check($sformatf("tx_line_cycle%0d", k), 32'(tx), 32'(fr[(k-1)/C]));
      check($sformatf("tx_ready_busy_cycle%0d", k), 32'(bus.tx_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    check("tx_ready_back", 32'(bus.tx_ready), 32'd1);
    check("tx_idle_after", 32'(tx), 32'd1);
    if (poke) begin
      repeat (2 * C) @(posedge clk);
      #1;
      check("tx_not_queued", 32'(tx), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] d;
    bit sb, pb, good;
    int np, lat, e0, o0;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    vt[0]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[1]  = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[2]  = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[3]  = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[4]  = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 4};
    vt[5]  = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vt[6]  = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[7]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[8]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vt[9]  = '{8'h07, 1'b1, 1'b1, PAR,  1'b0, 0};
    vt[10] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 2};

    // reset values, both while held and after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("post_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("post_rst_pulses", 32'(err_cnt + ovr_cnt), 32'd0);

    // transmit waveforms
    tx_send(8'hA5, 1'b1);
    tx_send(8'h07, 1'b0);
    for (int i = 0; i < 3; i++) tx_send(8'($urandom_range(0, 255)), 1'b0);

    // loopback
    loop = 1'b1;
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    lat = 0;
    while (bus.rx_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("loop_valid", 32'(bus.rx_valid), 32'd1);
    check($sformatf("loop_latency_%0d_near_%0d", lat, LAT), 32'(lat >= LAT - 1 && lat <= LAT + 1), 32'd1);
    q.push_back(8'h3C);
    pop_one();
    repeat (4 * C) @(posedge clk);
    #1;
    loop = 1'b0;

    // table vectors: FIFO fill, overrun, framing error, parity error
    for (int i = 0; i < 11; i++) begin
      rx_frame(vt[i].data, vt[i].stop_bit, vt[i].par_bad, vt[i].exp_err, vt[i].exp_ovr);
      for (int p = 0; p < vt[i].pops; p++) pop_one();
    end
    while (q.size() != 0) pop_one();

    // single-cycle low glitch is a false start
    e0 = err_cnt;
    o0 = ovr_cnt;
    rx_drv = 1'b0;
    @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (3 * C) @(posedge clk);
    #1;
    check("glitch_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("glitch_pulses", 32'((err_cnt - e0) + (ovr_cnt - o0)), 32'd0);

    // randomized frames against the queue model
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom_range(0, 255));
      sb   = ($urandom_range(0, 4) != 0);
      pb   = ($urandom_range(0, 4) == 0);
      good = sb && !(PAR && pb);
      rx_frame(d, sb, pb, !good, good && (q.size() == DEPTH));
      np = int'($urandom_range(0, q.size()));
      repeat (np) pop_one();
    end
    while (q.size() != 0) pop_one();

    // asynchronous reset in the middle of a TX frame with FIFO contents
    rx_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    repeat (2 * C) @(posedge clk);
    #1;
    check("pre_reset_tx_low", 32'(tx), 32'd0);
    check("pre_reset_rx_valid", 32'(bus.rx_valid), 32'd1);
    e0 = err_cnt;
    o0 = ovr_cnt;
    #2;
    rst = 1'b1;
    #1;
    check("reset_tx_immediate", 32'(tx), 32'd1);
    check("reset_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2 * C) @(posedge clk);
    #1;
    check("after_reset_tx", 32'(tx), 32'd1);
    check("after_reset_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("after_reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("after_reset_pulses", 32'((err_cnt - e0) + (ovr_cnt - o0)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bitty_uart.md
# bitty_uart

Parametrised full-duplex UART for the bitty Tiny Tapeout top, replacing fixed-width ad-hoc serial pin handling with a generic transceiver. Sits between the pad-level `uio_in[0]` / `uo_out[0]` serial pins and the bitty core's load/print logic. Provides configurable frame width, bit period and a receive FIFO with overrun reporting. Serial line idles high; frames are start bit (0), data LSB first, optional parity, and one stop bit (1).

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 4 and even.
- `DATA_BITS`, 8: payload bits per frame; legal range 5–9.
- `FIFO_DEPTH`, 4: RX FIFO entries; must be a power of two and ≥ 2.

Ports:
- `clk`, in, 1: single clock; every register is clocked on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: serial input, asynchronous to `clk`.
- `tx`, out, 1: serial output.
- `tx_data`, in, `DATA_BITS`: byte to transmit.
- `tx_valid`, in, 1: transmit request.
- `tx_ready`, out, 1: transmitter idle and able to accept a request.
- `rx_data`, out, `DATA_BITS`: FIFO head.
- `rx_valid`, out, 1: FIFO not empty.
- `rx_ready`, in, 1: consumer pops the head.
- `rx_overrun`, out, 1: one-cycle pulse when a good frame is dropped because the FIFO is full.
- `rx_frame_err`, out, 1: one-cycle pulse when a frame is discarded because its stop bit sampled 0.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_overrun`=0, `rx_frame_err`=0. FIFO is empty; both FSMs are in IDLE.
- **RX input conditioning:** `rx` passes through a 2-flop synchroniser before the RX FSM sees it.
- **RX FSM states:** IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE → START on a synchronised 1→0 transition.
  - START samples at `CLKS_PER_BIT/2`. If the line reads 1, the start is false: return to IDLE with no pulse.
  - DATA and PARITY sample every `CLKS_PER_BIT` cycles after the START mid-point. Data shifts in LSB first.
  - STOP samples its mid-point, then returns to IDLE immediately, so back-to-back frames are accepted.
  - STOP sample = 0: pulse `rx_frame_err`; nothing is pushed.
  - STOP sample = 1: push the byte. If the FIFO is full and no pop occurs that cycle, the byte is dropped and `rx_overrun` pulses.
- **RX FIFO:**
  - Head is registered on `rx_data`; pop on `rx_valid & rx_ready`.
  - Push and pop in the same cycle are both honoured, including when full; count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. Count width is log2(`FIFO_DEPTH`)+1.
  - `rx_data` holds its last value when the FIFO is empty.
- **TX FSM states:** IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - A handshake (`tx_valid & tx_ready`) latches `tx_data`. `tx_ready` drops the same edge.
  - Each bit is driven for exactly `CLKS_PER_BIT` cycles, LSB first.
  - `tx_ready` reasserts the cycle after the stop bit's last cycle.
  - `tx_valid` while `tx_ready`=0 is ignored; no queueing.
- **Reset mid-frame:** all state is cleared asynchronously. `tx` goes to 1 immediately. Any partial RX frame and all FIFO contents are lost.

## Timing
- TX: the handshake edge is cycle 0. `tx` falls at cycle 1 (registered output).
- TX frame length is F×`CLKS_PER_BIT` cycles, where F = `DATA_BITS`+2 (+1 with parity). `tx_ready` is high again at cycle F×`CLKS_PER_BIT`+1.
- RX: the push, `rx_valid` rise and either error pulse occur 2 (synchroniser) + (F−0.5)×`CLKS_PER_BIT` + 1 cycles after the `rx` falling edge, ±1 cycle for synchroniser phase.
- Pop: `rx_valid`/`rx_data` update on the edge following the handshake.

## Configuration
- `BITTY_UART_PARITY_EN` defined: an even-parity bit is inserted after the data bits on both TX and RX.
  - A bad RX parity discards the frame and pulses `rx_frame_err`, exactly as a bad stop bit does.
  - F = `DATA_BITS`+3.
- Macro undefined: no parity bit; parity logic is absent. F = `DATA_BITS`+2.

## Test plan
Bench settings: `CLKS_PER_BIT`=4, `DATA_BITS`=8, `FIFO_DEPTH`=4, parity off unless stated.
1. **Reset:** assert `rst` mid-simulation → `tx`=1, `tx_ready`=1, `rx_valid`=0, no pulses. Also assert during a TX frame → `tx` returns to 1 the same cycle.
2. **TX 0xA5:** `tx` is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. `tx_ready` is back at cycle 41.
3. **Loopback:** tie `tx` to `rx` and send 0x3C → `rx_valid` rises with `rx_data`=0x3C. Pop with `rx_ready` → `rx_valid`=0.
4. **Overrun:** drive 5 frames 0x01–0x05 with `rx_ready`=0 → FIFO holds 0x01–0x04 and `rx_overrun` pulses once on 0x05. Popping 4 times returns 0x01..0x04 in order.
5. **Errors and false start:**
   - Frame 0x55 with stop bit 0 → `rx_frame_err` pulse, `rx_valid` stays 0.
   - 1-cycle low glitch on `rx` → no push and no pulse.
6. **Parity (`BITTY_UART_PARITY_EN`):**
   - TX 0x07 → parity bit 1, frame 44 cycles.
   - RX 0x07 with parity 0 → `rx_frame_err` pulse, no push.
